ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined processor. It consumes the ID/EX bundle: control bits, RsE/RtE/RdE, data11/data22 and signImmE.
- It applies forwarding muxes and computes single-cycle ALU results.
- It runs an iterative multiply/divide unit with HI/LO registers, and asserts stallE back to the hazard unit while that unit is busy.
- Outputs feed the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width. HI/LO are WIDTH each. The iteration count equals WIDTH.

Ports:
- clk  in  1  clock. All state updates on negedge clk, in step with the pipeline registers.
- rst_n  in  1  synchronous active-low reset, sampled on negedge clk.
- regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE  in  1 each  ID/EX control.
- ALUControlE  in  4  operation select (encoding in package).
- ALUOpE  in  2  passed through unused except for decode sanity.
- RtE, RdE  in  5 each  destination candidates.
- data11, data22  in  WIDTH  register-file operands.
- signImmE  in  WIDTH  immediate; [10:6] is the shift amount.
- forwardAE, forwardBE  in  2 each  selects: 00 regfile, 10 ALUOutM, 01 resultW.
- ALUOutM, resultW  in  WIDTH  forwarded values.
- flushE  in  1  abort or bubble the instruction in EX.
- ALUOutE  out  WIDTH  result to EX/MEM.
- writeDataE  out  WIDTH  forwarded B operand (store data).
- writeRegE  out  5  RdE if regDstE, else RtE.
- zeroE  out  1  ALU result == 0.
- regWriteOutE, memToRegOutE, memWriteOutE  out  1 each  gated control.
- stallE  out  1  freeze IF/ID/EX; bubble EX/MEM.

Behaviour:
- Operand muxing: SrcA = forwardAE mux. B = forwardBE mux. SrcB = ALUSrcE ? signImmE : B. forwardAE/forwardBE = 11 is treated as 00.
- ALU operations (combinational, same cycle):
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100 (B << shamt), SRL 0101, SUB 0110.
  - SLT 0111 (signed, yields 1/0), NOR 1100.
  - MFHI 1101 returns HI; MFLO 1110 returns LO.
  - Unused codes return 0. ADD/SUB wrap modulo 2^WIDTH with no overflow trap.
- Multiply/divide codes: MULT 1000, MULTU 1001, DIV 1010, DIVU 1011.
  - Signed ops iterate on magnitudes and then fix the sign.
- FSM states IDLE, RUN, DONE.
  - IDLE: if an md op is in EX and flushE=0, the edge loads operands, sets cnt=WIDTH-1 and goes to RUN.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per edge. When cnt==0, HI/LO are written and the FSM goes to DONE; otherwise cnt decrements.
  - DONE: the next edge returns to IDLE. DONE prevents re-issue of the same, still-present instruction.
- stallE = (md op in EX and state != DONE) OR (MFHI/MFLO in EX and state == RUN).
  - An md op therefore stalls for WIDTH+1 cycles.
  - MFHI/MFLO right after DONE sees the new HI/LO.
- Gated control:
  - regWriteOutE, memToRegOutE and memWriteOutE are 0 when stallE=1, when flushE=1, or for md ops.
  - Otherwise they equal their inputs.
- Results:
  - MULT/MULTU: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
  - DIV/DIVU: LO = quotient, HI = remainder. The remainder takes the dividend's sign, and the quotient truncates toward zero.
  - Divide by zero: LO = all ones and HI = dividend. No trap.
  - DIV of INT_MIN by -1: LO = INT_MIN, HI = 0.
- flushE during RUN: aborts. The next edge goes to IDLE, HI/LO are unchanged and stallE drops after that edge.
- Reset: state = IDLE, cnt = 0, HI = LO = 0.
  - Combinational outputs follow inputs; stallE = 0 once reset is applied.
  - Reset mid-RUN discards the operation.

Decomposition:
- Package ex_pkg: ALUControl code constants, forward-select constants, FSM state enum, WIDTH default.
- One sub-module, muldiv_unit: owns the FSM, cnt, HI/LO and sign fix-up, and exports busy, hi and lo.
- ex_stage contains the forwarding muxes, ALU, writeReg mux, control gating and stall logic.

Test Plan:
- ADD: data11=5, data22=7, forward 00, ALUSrcE=0 -> ALUOutE=12, zeroE=0, writeRegE=RdE when regDstE=1. Then forwardAE=10 with ALUOutM=100 -> 107.
- SLT: -1 vs 1 gives 1. SUB 3-3 gives 0 with zeroE=1. SLL of 1 with shamt 31 gives 0x80000000.
- MULT: 0xFFFFFFFF x 2 held in EX -> stallE high exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=1, LO=0xFFFFFFFE. regWriteOutE=0 throughout.
- DIV: -7 / 2 -> LO=-3, HI=-1. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- MFLO issued directly behind a DIV: stallE stays high until DONE, then returns the new LO.
- flushE at RUN cycle 10 -> IDLE next edge, HI/LO keep their old values. rst_n=0 mid-RUN -> HI=LO=0, stallE=0.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU codes, forward selects and mul/div FSM states for the execute stage.
package ex_pkg;
    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFHI  = 4'b1101;
    localparam logic [3:0] ALU_MFLO  = 4'b1110;

    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

    function automatic logic is_md(input logic [3:0] c);
        return c == ALU_MULT || c == ALU_MULTU || c == ALU_DIV || c == ALU_DIVU;
    endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO.
// Works on magnitudes; signs are applied when the last step writes HI/LO.
module muldiv_unit
    import ex_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_md,
    input  logic             i_flush,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_run,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_t          r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p, w_step, w_prod;
    logic [WIDTH-1:0]   r_d, r_a, r_hi, r_lo, w_amag, w_bmag, w_q, w_r;
    logic [WIDTH:0]     w_sum, w_diff;
    logic               r_div, r_negq, r_negr, r_bz, w_sgn, w_load;

    assign w_sgn  = ~i_op[0];
    assign w_amag = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_bmag = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_load = r_state == MD_IDLE && i_md && !i_flush;

    // r_p holds {acc, multiplier} for mul and {remainder, quotient} for div
    assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_d} : '0);
    assign w_diff = r_p[2*WIDTH-1:WIDTH-1] - {1'b0, r_d};
    assign w_step = !r_div ? {w_sum, r_p[WIDTH-1:1]} :
                    w_diff[WIDTH] ? {r_p[2*WIDTH-2:0], 1'b0} :
                    {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
    assign w_prod = r_negq ? -w_step : w_step;
    assign w_q    = w_step[WIDTH-1:0];
    assign w_r    = w_step[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = (r_state == MD_IDLE) ? (w_load ? MD_RUN : MD_IDLE) :
                 (r_state == MD_RUN)  ? (i_flush ? MD_IDLE : (r_cnt == '0 ? MD_DONE : MD_RUN)) :
                 MD_IDLE;
    end

    always_ff @(negedge clk) begin
        r_state <= !rst_n ? MD_IDLE : w_next;
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_load) begin
            r_cnt  <= CW'(WIDTH-1);
            r_p    <= {{WIDTH{1'b0}}, w_amag};
            r_d    <= w_bmag;
            r_a    <= i_a;
            r_div  <= i_op[1];
            r_negq <= w_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_negr <= w_sgn & i_a[WIDTH-1];
            r_bz   <= i_b == '0;
        end else if (r_state == MD_RUN && !i_flush) begin
            r_p   <= w_step;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_hi <= !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_bz ? r_a : (r_negr ? -w_r : w_r);
                r_lo <= !r_div ? w_prod[WIDTH-1:0] : r_bz ? '1 : (r_negq ? -w_q : w_q);
            end
        end
    end

    assign o_run  = r_state == MD_RUN;
    assign o_done = r_state == MD_DONE;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage - forwarding muxes, single-cycle ALU, mul/div unit,
// control gating and the stall back to the hazard unit.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             regWriteE,
    input  logic             memToRegE,
    input  logic             memWriteE,
    input  logic             ALUSrcE,
    input  logic             regDstE,
    input  logic [3:0]       ALUControlE,
    input  logic [1:0]       ALUOpE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       RdE,
    input  logic [WIDTH-1:0] data11,
    input  logic [WIDTH-1:0] data22,
    input  logic [WIDTH-1:0] signImmE,
    input  logic [1:0]       forwardAE,
    input  logic [1:0]       forwardBE,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] resultW,
    input  logic             flushE,
    output logic [WIDTH-1:0] ALUOutE,
    output logic [WIDTH-1:0] writeDataE,
    output logic [4:0]       writeRegE,
    output logic             zeroE,
    output logic             regWriteOutE,
    output logic             memToRegOutE,
    output logic             memWriteOutE,
    output logic             stallE
);
    logic [WIDTH-1:0] w_srca, w_b, w_srcb, w_hi, w_lo;
    logic [4:0]       w_shamt;
    logic             w_md, w_mfx, w_run, w_done, w_ok, w_unused;

    assign w_srca  = forwardAE == FWD_MEM ? ALUOutM : forwardAE == FWD_WB ? resultW : data11;
    assign w_b     = forwardBE == FWD_MEM ? ALUOutM : forwardBE == FWD_WB ? resultW : data22;
    assign w_srcb  = ALUSrcE ? signImmE : w_b;
    assign w_shamt = signImmE[10:6];
    assign w_md    = is_md(ALUControlE);
    assign w_mfx   = ALUControlE == ALU_MFHI || ALUControlE == ALU_MFLO;
    assign w_unused = ^ALUOpE;

    muldiv_unit #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_md   (w_md),
        .i_flush(flushE),
        .i_op   (ALUControlE[1:0]),
        .i_a    (w_srca),
        .i_b    (w_b),
        .o_run  (w_run),
        .o_done (w_done),
        .o_hi   (w_hi),
        .o_lo   (w_lo)
    );

    always_comb begin
        case (ALUControlE)
            ALU_AND:  ALUOutE = w_srca & w_srcb;
            ALU_OR:   ALUOutE = w_srca | w_srcb;
            ALU_ADD:  ALUOutE = w_srca + w_srcb;
            ALU_XOR:  ALUOutE = w_srca ^ w_srcb;
            ALU_SLL:  ALUOutE = w_b << w_shamt;
            ALU_SRL:  ALUOutE = w_b >> w_shamt;
            ALU_SUB:  ALUOutE = w_srca - w_srcb;
            ALU_SLT:  ALUOutE = {{(WIDTH-1){1'b0}}, $signed(w_srca) < $signed(w_srcb)};
            ALU_NOR:  ALUOutE = ~(w_srca | w_srcb);
            ALU_MFHI: ALUOutE = w_hi;
            ALU_MFLO: ALUOutE = w_lo;
            default:  ALUOutE = '0;
        endcase
    end

    // a held md op stalls until DONE; MFHI/MFLO waits only while a result is in flight
    assign stallE       = rst_n & ((w_md & ~w_done) | (w_mfx & w_run));
    assign w_ok         = ~stallE & ~flushE & ~w_md;
    assign zeroE        = ALUOutE == '0;
    assign writeDataE   = w_b;
    assign writeRegE    = regDstE ? RdE : RtE;
    assign regWriteOutE = regWriteE & w_ok;
    assign memToRegOutE = memToRegE & w_ok;
    assign memWriteOutE = memWriteE & w_ok;
endmodule
